acc_spi_reader: RTL and testbench

- SPI master that initialises the board's ADXL362 accelerometer and then periodically burst-reads X/Y/Z acceleration.
- Presents the samples as 12-bit two's-complement words on x_acc/y_acc/z_acc, which feed the AHB system's accelerometer inputs.
- Sits at top level between the sensor pins and mfp_sys, in the HCLK domain.

---
 rtl/acc_spi_reader_if.sv | 24 ++
 rtl/acc_spi_reader.sv | 202 ++++++++++++++++++++
 tb/tb_acc_spi_reader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_spi_reader_if.sv
// SPI pins to the ADXL362 plus the sample outputs that feed the AHB system.
interface acc_spi_reader_if;
  logic        spi_miso;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic [11:0] x_acc;
  logic [11:0] y_acc;
  logic [11:0] z_acc;
  logic        acc_valid;
  logic        init_done;

  modport master (
    input  spi_miso,
    output spi_sclk, spi_mosi, spi_cs_n,
    output x_acc, y_acc, z_acc, acc_valid, init_done
  );

  modport slave (
    output spi_miso,
    input  spi_sclk, spi_mosi, spi_cs_n,
    input  x_acc, y_acc, z_acc, acc_valid, init_done
  );
endinterface

// File: rtl/acc_spi_reader.sv
// ADXL362 SPI master: powers the sensor into measure mode, then burst-reads X/Y/Z every SAMPLE_PERIOD.
// state   | meaning
// STARTUP | sensor power-up wait after reset
// CFG     | 3-byte POWER_CTL write (measure mode)
// GAP     | CS held high between frames
// IDLE    | waiting for a pending sample request
// RD      | 8-byte burst read of XL..ZH
// UPD     | load x/y/z outputs, pulse acc_valid
module acc_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 500000,
  parameter int STARTUP_WAIT  = 2500000
) (
  input logic              HCLK,
  input logic              HRESETn,
  acc_spi_reader_if.master bus
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int SW = $clog2(STARTUP_WAIT + 1);
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [DW-1:0] HALF_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST    = DW'(2 * CLK_DIV - 1);
  localparam logic [SW-1:0] START_LAST  = SW'(STARTUP_WAIT - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

  localparam logic [63:0] CFG_FRAME = {8'h0A, 8'h2D, 8'h02, 40'h0};
  localparam logic [63:0] RD_FRAME  = {8'h0B, 8'h0E, 48'h0};

  localparam logic [2:0] ST_STARTUP = 3'd0;
  localparam logic [2:0] ST_CFG     = 3'd1;
  localparam logic [2:0] ST_GAP     = 3'd2;
  localparam logic [2:0] ST_IDLE    = 3'd3;
  localparam logic [2:0] ST_RD      = 3'd4;
  localparam logic [2:0] ST_UPD     = 3'd5;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_LO    = 2'd1;
  localparam logic [1:0] PH_HI    = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  logic [2:0]    state;
  logic [1:0]    phase;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [63:0]   tx_sr;
  logic [6:0]    rx_byte;
  logic [7:0]    rx_full;
  logic [7:0]    x_lo, y_lo, z_lo;
  logic [3:0]    x_hi, y_hi, z_hi;
  logic [SW-1:0] st_cnt;
  logic [PW-1:0] tmr;
  logic          pending;
  logic          tick;
  logic          rd_enter;
  logic          cs_n, sclk, mosi;
  logic [11:0]   x_acc, y_acc, z_acc;
  logic          acc_valid, init_done;

  assign bus.spi_cs_n  = cs_n;
  assign bus.spi_sclk  = sclk;
  assign bus.spi_mosi  = mosi;
  assign bus.x_acc     = x_acc;
  assign bus.y_acc     = y_acc;
  assign bus.z_acc     = z_acc;
  assign bus.acc_valid = acc_valid;
  assign bus.init_done = init_done;

  assign rx_full  = {rx_byte, bus.spi_miso};
  assign tick     = init_done && (tmr == PERIOD_LAST);
  assign rd_enter = (state == ST_IDLE) && pending;

  // A wrap coinciding with RD entry wins, so that request is not lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmr     <= '0;
      pending <= 1'b0;
    end else begin
      if (init_done) tmr <= tick ? '0 : tmr + PW'(1);
      pending <= tick | (pending & ~rd_enter);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_STARTUP;
      phase     <= PH_SETUP;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_byte   <= '0;
      x_lo      <= '0;
      y_lo      <= '0;
      z_lo      <= '0;
      x_hi      <= '0;
      y_hi      <= '0;
      z_hi      <= '0;
      st_cnt    <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      x_acc     <= '0;
      y_acc     <= '0;
      z_acc     <= '0;
      acc_valid <= 1'b0;
      init_done <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      case (state)
        ST_STARTUP: begin
          if (st_cnt == START_LAST) begin
            state   <= ST_CFG;
            cs_n    <= 1'b0;
            phase   <= PH_SETUP;
            div_cnt <= HALF_LAST;
            bit_cnt <= 6'd23;
            tx_sr   <= CFG_FRAME;
          end else begin
            st_cnt <= st_cnt + SW'(1);
          end
        end
        ST_CFG, ST_RD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DW'(1);
          end else begin
            div_cnt <= HALF_LAST;
            case (phase)
              PH_SETUP: begin
                phase <= PH_LO;
                mosi  <= tx_sr[63];
                tx_sr <= {tx_sr[62:0], 1'b0};
              end
              PH_LO: begin
                phase   <= PH_HI;
                sclk    <= 1'b1;
                rx_byte <= rx_full[6:0];
                // bit_cnt[5:3] counts bytes down: 5..0 are XL, XH, YL, YH, ZL, ZH
                if (state == ST_RD && bit_cnt[2:0] == 3'd0) begin
                  case (bit_cnt[5:3])
                    3'd5:    x_lo <= rx_full;
                    3'd4:    x_hi <= rx_full[3:0];
                    3'd3:    y_lo <= rx_full;
                    3'd2:    y_hi <= rx_full[3:0];
                    3'd1:    z_lo <= rx_full;
                    3'd0:    z_hi <= rx_full[3:0];
                    default: ;
                  endcase
                end
              end
              PH_HI: begin
                sclk <= 1'b0;
                if (bit_cnt == '0) begin
                  phase <= PH_HOLD;
                end else begin
                  phase   <= PH_LO;
                  bit_cnt <= bit_cnt - 6'd1;
                  mosi    <= tx_sr[63];
                  tx_sr   <= {tx_sr[62:0], 1'b0};
                end
              end
              PH_HOLD: begin
                cs_n <= 1'b1;
                mosi <= 1'b0;
                if (state == ST_CFG) begin
                  init_done <= 1'b1;
                  state     <= ST_GAP;
                  div_cnt   <= GAP_LAST;
                end else begin
                  state     <= ST_UPD;
                  x_acc     <= {x_hi, x_lo};
                  y_acc     <= {y_hi, y_lo};
                  z_acc     <= {z_hi, z_lo};
                  acc_valid <= 1'b1;
                end
              end
              default: phase <= PH_SETUP;
            endcase
          end
        end
        ST_UPD: begin
          state   <= ST_GAP;
          div_cnt <= GAP_LAST;
        end
        ST_GAP: begin
          if (div_cnt == '0) state <= ST_IDLE;
          else               div_cnt <= div_cnt - DW'(1);
        end
        ST_IDLE: begin
          if (pending) begin
            state   <= ST_RD;
            cs_n    <= 1'b0;
            phase   <= PH_SETUP;
            div_cnt <= HALF_LAST;
            bit_cnt <= 6'd63;
            tx_sr   <= RD_FRAME;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_spi_reader.sv
// Directed bench for acc_spi_reader with an ADXL362-style SPI slave and frame timing monitor.
module tb_acc_spi_reader;
  logic HCLK = 1'b0;
  logic HRESETn;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  acc_spi_reader_if bus ();
  acc_spi_reader_if bus_f ();

  acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(400), .STARTUP_WAIT(10)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
  acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(100), .STARTUP_WAIT(10)) dut_fast (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus_f));

  assign bus_f.spi_miso = 1'b0;

  // sensor model, mode 0: next bit presented after each SCLK fall
  logic [63:0] sl_frame;
  int          sl_idx   = 0;
  logic        sl_psclk = 1'b0;
  always @(negedge HCLK) begin
    if (bus.spi_cs_n !== 1'b0) begin
      sl_idx       <= 0;
      bus.spi_miso <= sl_frame[63];
    end else if (sl_psclk && !bus.spi_sclk) begin
      sl_idx <= sl_idx + 1;
      if (sl_idx < 63) bus.spi_miso <= sl_frame[62 - sl_idx];
    end
    sl_psclk <= bus.spi_sclk;
  end

  // frame monitor on the slow instance
  logic        pcs = 1'b1, psclk = 1'b0, pmosi = 1'b0;
  int          m_len = 0, m_bits = 0, m_first = -1, m_last = 0, m_viol = 0;
  logic [63:0] m_data = '0;
  int          f_len = 0, f_bits = 0, f_setup = 0, f_hold = 0, f_count = 0;
  logic [63:0] f_data = '0;
  always @(negedge HCLK) begin
    if (!bus.spi_cs_n) begin
      if (pcs) begin
        m_len <= 1; m_bits <= 0; m_data <= '0; m_first <= -1; m_last <= 0;
      end else begin
        m_len <= m_len + 1;
        if (bus.spi_sclk && !psclk) begin
          m_data <= {m_data[62:0], bus.spi_mosi};
          m_bits <= m_bits + 1;
          m_last <= m_len;
          if (m_first < 0) m_first <= m_len;
        end
      end
      if (bus.spi_sclk && bus.spi_mosi !== pmosi) m_viol <= m_viol + 1;
    end else begin
      if (bus.spi_sclk) m_viol <= m_viol + 1;
      if (!pcs) begin
        f_len <= m_len; f_bits <= m_bits; f_data <= m_data;
        f_setup <= m_first; f_hold <= m_len - m_last; f_count <= f_count + 1;
      end
    end
    pcs <= bus.spi_cs_n; psclk <= bus.spi_sclk; pmosi <= bus.spi_mosi;
  end

  int          unstable = 0;
  logic [35:0] p_xyz = '0;
  always @(negedge HCLK) begin
    if (HRESETn && !bus.acc_valid && {bus.x_acc, bus.y_acc, bus.z_acc} !== p_xyz)
      unstable <= unstable + 1;
    p_xyz <= {bus.x_acc, bus.y_acc, bus.z_acc};
  end

  // fast instance: CS-high gaps and acc_valid spacing inside a window
  int   f_lo = 0, f_hi = 0, fr_rise = -1, fr_acc = -1, fr_frames = 0;
  int   fr_gmin = 1000000, fr_gmax = 0, fr_imin = 1000000, fr_imax = 0;
  logic fr_pcs = 1'b1;
  always @(negedge HCLK) begin
    fr_pcs <= bus_f.spi_cs_n;
    if (cyc >= f_lo && cyc < f_hi) begin
      if (bus_f.spi_cs_n && !fr_pcs) fr_rise <= cyc;
      if (!bus_f.spi_cs_n && fr_pcs && fr_rise >= 0) begin
        fr_frames <= fr_frames + 1;
        if (cyc - fr_rise < fr_gmin) fr_gmin <= cyc - fr_rise;
        if (cyc - fr_rise > fr_gmax) fr_gmax <= cyc - fr_rise;
      end
      if (bus_f.acc_valid) begin
        if (fr_acc >= 0 && cyc - fr_acc < fr_imin) fr_imin <= cyc - fr_acc;
        if (fr_acc >= 0 && cyc - fr_acc > fr_imax) fr_imax <= cyc - fr_acc;
        fr_acc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic wait_cs(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.spi_cs_n !== level && n < budget) begin step(1); n++; end
    if (bus.spi_cs_n !== level) chk(tag, 64'(bus.spi_cs_n), 64'(level));
  endtask

  task automatic wait_frame(input int budget, input string tag);
    wait_cs(1'b0, budget, tag);
    wait_cs(1'b1, 400, tag);
    @(negedge HCLK);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (bus.acc_valid !== 1'b1 && n < budget) begin step(1); n++; end
    if (bus.acc_valid !== 1'b1) chk(tag, 64'(bus.acc_valid), 64'd1);
  endtask

  int n, t0, t_prev, snap;

  initial begin
    HRESETn  = 1'b0;
    sl_frame = {16'h0, 8'h34, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'hF8};
    step(3);
    chk("rst_cs_n", 64'(bus.spi_cs_n), 64'd1);
    chk("rst_sclk_mosi", 64'({bus.spi_sclk, bus.spi_mosi}), 64'd0);
    chk("rst_outputs", 64'({bus.x_acc, bus.y_acc, bus.z_acc, bus.acc_valid, bus.init_done}), 64'd0);

    HRESETn = 1'b1;
    n = 0;
    while (bus.spi_cs_n === 1'b1 && n < 50) begin step(1); n++; end
    chk("startup_wait", 64'(n), 64'd10);
    chk("init_low_during_cfg", 64'(bus.init_done), 64'd0);

    wait_frame(50, "cfg_timeout");
    chk("cfg_bits", 64'(f_bits), 64'd24);
    chk("cfg_data", f_data, 64'h0A2D02);
    chk("cfg_len", 64'(f_len), 64'd100);
    chk("cfg_setup", 64'(f_setup), 64'd4);
    chk("cfg_hold", 64'(f_hold), 64'd4);
    chk("init_done_at_cs_rise", 64'(bus.init_done), 64'd1);
    t0 = cyc;

    wait_cs(1'b0, 1000, "first_read_timeout");
    chk("first_read_delay", 64'((cyc - t0 >= 400) && (cyc - t0 <= 402)), 64'd1);
    wait_frame(10, "rd_timeout");
    chk("rd_bits", 64'(f_bits), 64'd64);
    chk("rd_data", f_data, 64'h0B0E_0000_0000_0000);
    chk("rd_len", 64'(f_len), 64'd260);
    chk("rd_setup", 64'(f_setup), 64'd4);
    chk("rd_hold", 64'(f_hold), 64'd4);
    wait_valid(3, "valid_timeout");
    chk("xyz_first", 64'({bus.x_acc, bus.y_acc, bus.z_acc}), 64'h234FFF800);
    t_prev = cyc;
    step(1);
    chk("valid_one_cycle", 64'(bus.acc_valid), 64'd0);

    sl_frame = {16'h0, 8'hFF, 8'h57, 8'h00, 8'h08, 8'h01, 8'hF0};
    snap = unstable;
    f_lo = cyc + 300;
    f_hi = cyc + 2000;
    for (int k = 0; k < 5; k++) begin
      wait_valid(600, "period_timeout");
      chk("period", 64'(cyc - t_prev), 64'd400);
      t_prev = cyc;
      step(1);
    end
    chk("xyz_second", 64'({bus.x_acc, bus.y_acc, bus.z_acc}), 64'h7FF800001);
    chk("stable_between", 64'(unstable - snap), 64'd0);
    chk("fast_frames", 64'(fr_frames >= 5), 64'd1);
    chk("fast_gap_min", 64'(fr_gmin >= 4), 64'd1);
    chk("fast_gap_max", 64'(fr_gmax <= 6), 64'd1);
    chk("fast_ivl_min", 64'(fr_imin >= 264), 64'd1);
    chk("fast_ivl_max", 64'(fr_imax <= 266), 64'd1);

    wait_cs(1'b0, 600, "mid_read_timeout");
    step(4 + 30 * 4);
    chk("in_read_before_reset", 64'(bus.spi_cs_n), 64'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_cs_sclk", 64'({bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi}), 64'b100);
    chk("async_outputs", 64'({bus.x_acc, bus.y_acc, bus.z_acc, bus.acc_valid, bus.init_done}), 64'd0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    n = 0;
    while (bus.spi_cs_n === 1'b1 && n < 50) begin step(1); n++; end
    chk("restart_wait", 64'(n), 64'd10);
    wait_frame(50, "recfg_timeout");
    chk("recfg_data", f_data, 64'h0A2D02);
    chk("recfg_len", 64'(f_len), 64'd100);
    wait_valid(1200, "reread_timeout");
    chk("xyz_after_reset", 64'({bus.x_acc, bus.y_acc, bus.z_acc}), 64'h7FF800001);
    chk("mosi_sclk_timing", 64'(m_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
